// File: rtl/seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Blank codes, scan states and the leading-zero mask function.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic {BLANK, SHOW} state_t;

  // Bit i set when digits i..ndig-1 are all zero; digit 0 never set.
  function automatic logic [7:0] lz_mask(
    input logic [31:0] shadow,
    input int          ndig
  );
    logic z;
    z       = 1'b1;
    lz_mask = '0;
    for (int i = 7; i >= 1; i--) begin
      if (i < ndig) begin
        z          = z & (shadow[4*i +: 4] == 4'h0);
        lz_mask[i] = z;
      end
    end
  endfunction

endpackage

// File: rtl/Siete_segs.sv
// Hex to seven-segment decoder, segment order abcdefg.
// Outputs are active low: 0 lights the segment.
module Siete_segs (
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  always_comb begin
    segs = 7'b1111111;
    case (hex)
      4'h0: segs = 7'b0000001;
      4'h1: segs = 7'b1001111;
      4'h2: segs = 7'b0010010;
      4'h3: segs = 7'b0000110;
      4'h4: segs = 7'b1001100;
      4'h5: segs = 7'b0100100;
      4'h6: segs = 7'b0100000;
      4'h7: segs = 7'b0001111;
      4'h8: segs = 7'b0000000;
      4'h9: segs = 7'b0000100;
      4'hA: segs = 7'b0001000;
      4'hB: segs = 7'b1100000;
      4'hC: segs = 7'b0110001;
      4'hD: segs = 7'b1000010;
      4'hE: segs = 7'b0110000;
      4'hF: segs = 7'b0111000;
      default: segs = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_timer.sv
// Scan timer: blank/show phase counter and digit index.
// show/slot describe the phase entered on the coming edge.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter  int NDIG      = 4,
  parameter  int SHOW_CYC  = 50000,
  parameter  int BLANK_CYC = 64,
  localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC,
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1,
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          show,
  output logic [IW-1:0] slot,
  output logic          frame_end
);

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt + 1'b1;
    frame_end = 1'b0;
    unique case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt == CW'(SHOW_CYC - 1)) begin
          state_d   = BLANK;
          cnt_d     = '0;
          frame_end = (idx == IW'(NDIG - 1));
          idx_d     = frame_end ? '0 : idx + 1'b1;
        end
      end
    endcase
  end

  assign show = (state_d == SHOW);
  assign slot = idx_d;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller.
// Frame-synchronous value update, blanking gap, leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic [NDIG-1:0]   dp,
  input  logic [NDIG-1:0]   dig_en,
  input  logic              lz_suppress,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        segs,
  output logic              dp_n,
  output logic              frame_done,
  output logic              pending
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic              show;
  logic [IW-1:0]     slot;
  logic              frame_end;
  logic [4*NDIG-1:0] shadow, staged;
  logic [31:0]       sh32;
  logic [7:0]        lzm, sel;
  logic [3:0]        digit;
  logic [6:0]        dec;
  logic              lit;
  logic [NDIG-1:0]   an_d;

  seg_scan_timer #(
    .NDIG      (NDIG),
    .SHOW_CYC  (SHOW_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .show      (show),
    .slot      (slot),
    .frame_end (frame_end)
  );

  Siete_segs u_dec (
    .hex  (digit),
    .segs (dec)
  );

  always_comb begin
    sh32              = '0;
    sh32[4*NDIG-1:0]  = shadow;
    lzm               = lz_mask(sh32, NDIG);
    sel               = 8'(1) << slot;
    digit             = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (slot == IW'(i)) digit = shadow[4*i +: 4];
    end
    lit               = show & dig_en[slot] & ~(lz_suppress & |(lzm & sel));
    an_d              = AN_OFF[NDIG-1:0];
    an_d[slot]        = 1'b0;
  end

  // Outputs follow the phase being entered on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= AN_OFF[NDIG-1:0];
      segs       <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= lit ? an_d : AN_OFF[NDIG-1:0];
      segs       <= lit ? dec : SEG_OFF;
      dp_n       <= ~(lit & dp[slot]);
      frame_done <= frame_end;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      staged  <= '0;
      pending <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        shadow  <= value;
        staged  <= value;
        pending <= 1'b0;
      end else if (pending) begin
        shadow  <= staged;
        pending <= 1'b0;
      end
    end else if (load) begin
      staged  <= value;
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NDIG=4, SHOW=4, BLANK=2).
// A frame-position model queues expected outputs per clock edge.
module tb_seg_scan_ctrl;

  localparam int FR = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  dig_en;
  logic        lz_suppress;
  logic [3:0]  an;
  logic [6:0]  segs;
  logic        dp_n;
  logic        frame_done;
  logic        pending;

  seg_scan_ctrl #(
    .NDIG      (4),
    .SHOW_CYC  (4),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .load        (load),
    .dp          (dp),
    .dig_en      (dig_en),
    .lz_suppress (lz_suppress),
    .an          (an),
    .segs        (segs),
    .dp_n        (dp_n),
    .frame_done  (frame_done),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] segs;
    logic       dpn;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t q[$];

  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int          n_vec = 0;
  int          n_err = 0;
  int          t = 0;
  int          fd_cnt = 0;
  logic [15:0] m_sh = '0;
  logic [15:0] m_st = '0;
  logic        m_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_step();
    int   nt, p, slot;
    logic fe, show, z, sup, lit;
    exp_t e;
    if (!rst_n) begin
      t      = 0;
      m_sh   = '0;
      m_st   = '0;
      m_pend = 1'b0;
      q.delete();
    end else begin
      nt   = t + 1;
      p    = nt % FR;
      fe   = (p == 0);
      slot = p / 6;
      show = (p % 6) >= 2;
      z    = 1'b1;
      for (int k = slot; k < 4; k++)
        if (m_sh[4*k +: 4] != 4'h0) z = 1'b0;
      sup    = lz_suppress && (slot != 0) && z;
      lit    = show && dig_en[slot] && !sup;
      e.an   = lit ? ~(4'b0001 << slot) : 4'hF;
      e.segs = lit ? tbl[m_sh[4*slot +: 4]] : 7'h7F;
      e.dpn  = lit ? ~dp[slot] : 1'b1;
      e.fd   = fe;
      if (fe) begin
        if (load) begin
          m_sh   = value;
          m_st   = value;
          m_pend = 1'b0;
        end else if (m_pend) begin
          m_sh   = m_st;
          m_pend = 1'b0;
        end
      end else if (load) begin
        m_st   = value;
        m_pend = 1'b1;
      end
      e.pend = m_pend;
      q.push_back(e);
      t = nt;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n || q.size() == 0) begin
      check("rst_an",   an,         4'hF);
      check("rst_segs", segs,       7'h7F);
      check("rst_dpn",  dp_n,       1'b1);
      check("rst_fd",   frame_done, 1'b0);
      check("rst_pend", pending,    1'b0);
    end else begin
      e = q.pop_front();
      check("an",   an,         e.an);
      check("segs", segs,       e.segs);
      check("dp_n", dp_n,       e.dpn);
      check("fd",   frame_done, e.fd);
      check("pend", pending,    e.pend);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 30; i++) begin
      if (t % FR == p) return;
      tick(1);
    end
    check("wait_pos_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  initial begin
    int c0;
    rst_n       = 1'b0;
    load        = 1'b0;
    value       = '0;
    dp          = '0;
    dig_en      = 4'hF;
    lz_suppress = 1'b0;
    tick(3);
    rst_n = 1'b1;

    c0 = fd_cnt;
    tick(50);
    check("fd_two_frames", 32'(fd_cnt - c0), 2);

    wait_pos(8);
    do_load(16'h1A0F);
    check("pend_set", pending, 1'b1);
    wait_pos(1);
    check("pend_clr", pending, 1'b0);
    tick(24);

    lz_suppress = 1'b1;
    do_load(16'h0050);
    tick(48);
    do_load(16'h0000);
    tick(48);
    lz_suppress = 1'b0;

    wait_pos(5);
    do_load(16'h1111);
    wait_pos(10);
    do_load(16'h2222);
    tick(30);
    wait_pos(23);
    do_load(16'h3333);
    check("pend_fe_load", pending, 1'b0);
    tick(24);

    dig_en = 4'b1011;
    dp     = 4'b0100;
    tick(24);
    dig_en = 4'hF;
    tick(24);
    dp     = '0;

    wait_pos(10);
    do_load(16'h4567);
    wait_pos(15);
    check("pend_pre_rst", pending, 1'b1);
    check("an_pre_rst", an, 4'hB);
    #1 rst_n = 1'b0;
    #1;
    check("an_mid_rst", an, 4'hF);
    check("pend_mid_rst", pending, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
